decode_ctrl_stage: RTL and testbench

//  Registered, parametrised control-decode stage for the RV32 pipeline CPU: takes a fetched

---
 rtl/decode_ctrl_stage.sv | 202 ++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// RV32 control-decode stage: decodes a fetched instruction into a datapath control word
// and registers it with PC/instr behind a valid/ready handshake, with flush and illegal count.
module decode_ctrl_stage #(
  parameter int PC_W       = 32,
  parameter bit ENABLE_MUL = 1'b0,
  parameter bit ENABLE_SYS = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [1:0]       out_alu_op,
  output logic             alu_src,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             jump,
  output logic             jump_addr_src,
  output logic             imm_load,
  output logic             wb_src,
  output logic [2:0]       dmem_op,
  output logic             mul_en,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jump;
    logic       jump_addr_src;
    logic       imm_load;
    logic       wb_src;
    logic [2:0] dmem_op;
    logic       mul_en;
  } ctrl_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  ctrl_t            w_ctrl;
  logic             w_illegal;
  logic             w_accept;
  logic             w_xfer;

  ctrl_t            r_ctrl;
  logic             r_valid;
  logic             r_illegal;
  logic [31:0]      r_instr;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];

  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    case (w_opc)
      7'b0110111: begin // LUI
        w_ctrl.reg_write = 1'b1;
        w_ctrl.imm_load  = 1'b1;
      end
      7'b0010111: begin // AUIPC
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_src    = 1'b1;
      end
      7'b1101111: begin // JAL
        w_ctrl.jump      = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      7'b1100111: begin // JALR
        w_ctrl.jump          = 1'b1;
        w_ctrl.jump_addr_src = 1'b1;
        w_ctrl.reg_write     = 1'b1;
        w_ctrl.alu_src       = 1'b1;
        if (w_f3 != 3'b000) w_illegal = 1'b1;
      end
      7'b1100011: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = 2'b01;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_illegal = 1'b1;
      end
      7'b0000011: begin
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        case (w_f3)
          3'b000:  w_ctrl.dmem_op = 3'b010;
          3'b001:  w_ctrl.dmem_op = 3'b011;
          3'b010:  w_ctrl.dmem_op = 3'b001;
          3'b100:  w_ctrl.dmem_op = 3'b100;
          3'b101:  w_ctrl.dmem_op = 3'b101;
          default: w_illegal      = 1'b1;
        endcase
      end
      7'b0100011: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        case (w_f3)
          3'b000:  w_ctrl.dmem_op = 3'b010;
          3'b001:  w_ctrl.dmem_op = 3'b011;
          3'b010:  w_ctrl.dmem_op = 3'b001;
          default: w_illegal      = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = 2'b11;
        // shift-immediate encodings reuse funct7 as a qualifier
        if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_illegal = 1'b1;
        if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_illegal = 1'b1;
      end
      7'b0110011: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = 2'b10;
        if (w_f7 == 7'b0000000) begin
          w_illegal = 1'b0;
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_illegal = 1'b0;
        end else if (w_f7 == 7'b0000001 && ENABLE_MUL) begin
          w_ctrl.mul_en = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      7'b0001111, 7'b1110011: begin
        if (!ENABLE_SYS) w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) w_illegal = 1'b1;
    if (w_illegal) w_ctrl = '0;
  end

  assign in_ready = !rst && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;
  assign w_xfer   = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_cnt     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_ctrl    <= w_ctrl;
      r_illegal <= w_illegal;
      r_instr   <= in_instr;
      r_pc      <= in_pc;
      if (w_illegal && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign out_instr     = r_instr;
  assign out_pc        = r_pc;
  assign out_alu_op    = r_ctrl.alu_op;
  assign alu_src       = r_ctrl.alu_src;
  assign branch        = r_ctrl.branch;
  assign mem_read      = r_ctrl.mem_read;
  assign mem_write     = r_ctrl.mem_write;
  assign reg_write     = r_ctrl.reg_write;
  assign mem_to_reg    = r_ctrl.mem_to_reg;
  assign jump          = r_ctrl.jump;
  assign jump_addr_src = r_ctrl.jump_addr_src;
  assign imm_load      = r_ctrl.imm_load;
  assign wb_src        = r_ctrl.wb_src;
  assign dmem_op       = r_ctrl.dmem_op;
  assign mul_en        = r_ctrl.mul_en;
  assign illegal       = r_illegal;
  assign illegal_cnt   = r_cnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: dut0 has M-ext off and a 2-bit counter,
// dut1 has M-ext on; both see the same input stream.
module tb_decode_ctrl_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready, out_valid, alu_src, branch, mem_read, mem_write, reg_write;
  logic        mem_to_reg, jump, jump_addr_src, imm_load, wb_src, mul_en, illegal;
  logic [31:0] out_instr, out_pc;
  logic [1:0]  out_alu_op;
  logic [2:0]  dmem_op;
  logic [1:0]  illegal_cnt;

  logic        b_in_ready, b_out_valid, b_alu_src, b_branch, b_mem_read, b_mem_write, b_reg_write;
  logic        b_mem_to_reg, b_jump, b_jump_addr_src, b_imm_load, b_wb_src, b_mul_en, b_illegal;
  logic [31:0] b_out_instr, b_out_pc;
  logic [1:0]  b_out_alu_op;
  logic [2:0]  b_dmem_op;
  logic [7:0]  b_illegal_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI = 32'h00A28293;
  localparam logic [31:0] LW   = 32'h0002A303;
  localparam logic [31:0] MUL  = 32'h02C58533;
  localparam logic [31:0] SW   = 32'h0062A223;
  localparam logic [31:0] BAD  = 32'hFFFFFFFF;

  decode_ctrl_stage #(.PC_W(32), .ENABLE_MUL(1'b0), .ENABLE_SYS(1'b1), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_alu_op(out_alu_op), .alu_src(alu_src),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .jump(jump), .jump_addr_src(jump_addr_src), .imm_load(imm_load),
    .wb_src(wb_src), .dmem_op(dmem_op), .mul_en(mul_en), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  decode_ctrl_stage #(.PC_W(32), .ENABLE_MUL(1'b1), .ENABLE_SYS(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_out_instr), .out_pc(b_out_pc), .out_alu_op(b_out_alu_op), .alu_src(b_alu_src),
    .branch(b_branch), .mem_read(b_mem_read), .mem_write(b_mem_write), .reg_write(b_reg_write),
    .mem_to_reg(b_mem_to_reg), .jump(b_jump), .jump_addr_src(b_jump_addr_src),
    .imm_load(b_imm_load), .wb_src(b_wb_src), .dmem_op(b_dmem_op), .mul_en(b_mul_en),
    .illegal(b_illegal), .illegal_cnt(b_illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (illegal_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", illegal_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h/%h want 0/0", out_instr, out_pc); end
    checks++; if ({reg_write, mem_read, mem_write, branch, jump, illegal, out_alu_op, dmem_op} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got nonzero control word"); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0b want 1", out_valid); end
    checks++; if (out_alu_op !== 2'b11) begin errors++; $display("FAIL addi_alu_op: got %b want 11", out_alu_op); end
    checks++; if (alu_src !== 1'b1 || reg_write !== 1'b1) begin errors++; $display("FAIL addi_src_rw: got %0b%0b want 11", alu_src, reg_write); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal: got %0b want 0", illegal); end
    checks++; if (out_instr !== ADDI || out_pc !== 32'h100) begin errors++; $display("FAIL addi_regs: got %h/%h want %h/100", out_instr, out_pc, ADDI); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_hold();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = LW; in_pc = 32'h104;
    tick();
    in_instr = ADDI; in_pc = 32'h108;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %0b want 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_instr !== LW || out_pc !== 32'h104) begin
        errors++; $display("FAIL hold_stable[%0d]: got v=%0b %h/%h want 1 %h/104", k, out_valid, out_instr, out_pc, LW); end
      checks++; if (dmem_op !== 3'b001 || mem_to_reg !== 1'b1 || mem_read !== 1'b1) begin
        errors++; $display("FAIL hold_lw_ctrl[%0d]: got op=%b m2r=%0b rd=%0b want 001 1 1", k, dmem_op, mem_to_reg, mem_read); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %0b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_mul();
    in_valid = 1'b1; in_instr = MUL; in_pc = 32'h10C; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || reg_write !== 1'b0) begin
      errors++; $display("FAIL mul_off: got v=%0b ill=%0b rw=%0b want 1 1 0", out_valid, illegal, reg_write); end
    checks++; if (out_alu_op !== 2'b00 || mul_en !== 1'b0) begin errors++; $display("FAIL mul_off_ctrl: got op=%b mul=%0b want 00 0", out_alu_op, mul_en); end
    checks++; if (illegal_cnt !== 2'd1) begin errors++; $display("FAIL mul_off_cnt: got %0d want 1", illegal_cnt); end
    checks++; if (b_mul_en !== 1'b1 || b_illegal !== 1'b0 || b_reg_write !== 1'b1) begin
      errors++; $display("FAIL mul_on: got mul=%0b ill=%0b rw=%0b want 1 0 1", b_mul_en, b_illegal, b_reg_write); end
    checks++; if (b_illegal_cnt !== 8'd0) begin errors++; $display("FAIL mul_on_cnt: got %0d want 0", b_illegal_cnt); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h110;
    tick();
    flush = 1'b1; in_instr = BAD; in_pc = 32'h114; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    checks++; if (illegal_cnt !== 2'd1) begin errors++; $display("FAIL flush_cnt: got %0d want 1", illegal_cnt); end
    checks++; if (b_illegal_cnt !== 8'd0) begin errors++; $display("FAIL flush_cnt_b: got %0d want 0", b_illegal_cnt); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = BAD; in_pc = 32'h118;
    tick();
    in_valid = 1'b0;
    checks++; if (illegal_cnt !== 2'd2 || illegal !== 1'b1) begin errors++; $display("FAIL midrst_pre: got cnt=%0d ill=%0b want 2 1", illegal_cnt, illegal); end
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || illegal_cnt !== 2'd0 || out_instr !== 32'h0 || illegal !== 1'b0) begin
      errors++; $display("FAIL midrst: got v=%0b cnt=%0d instr=%h ill=%0b want 0 0 0 0", out_valid, illegal_cnt, out_instr, illegal); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    out_ready = 1'b1; in_valid = 1'b1; in_instr = BAD;
    for (int i = 0; i < 5; i++) begin
      in_pc = 32'h200 + 32'(i * 4);
      tick();
      checks++; if (illegal_cnt !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, illegal_cnt, exp_cnt[i]); end
      checks++; if (b_illegal_cnt !== 8'(i + 1)) begin errors++; $display("FAIL sat_cnt_b[%0d]: got %0d want %0d", i, b_illegal_cnt, i + 1); end
      checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || dmem_op !== 3'b000 || out_alu_op !== 2'b00 || reg_write !== 1'b0) begin
        errors++; $display("FAIL sat_word[%0d]: got v=%0b ill=%0b op=%b alu=%b rw=%0b", i, out_valid, illegal, dmem_op, out_alu_op, reg_write); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_table();
    logic [31:0] t_instr [13];
    logic        t_ill   [13];
    logic        t_rw    [13];
    logic [1:0]  t_alu   [13];
    t_instr = '{32'h123452B7, 32'h00000063, 32'h00002063, 32'h0002B303, 32'h000080E7,
                32'h000090E7, 32'h40029293, 32'h4002D293, 32'h40B50533, 32'h40B51533,
                32'h0000000F, 32'h00000073, 32'h00A28291};
    t_ill   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    t_rw    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t_alu   = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_instr = t_instr[i]; in_pc = 32'h300 + 32'(i * 4);
      tick();
      checks++; if (out_valid !== 1'b1 || out_instr !== t_instr[i] || illegal !== t_ill[i] || reg_write !== t_rw[i] || out_alu_op !== t_alu[i]) begin
        errors++; $display("FAIL decode[%0d] %h: got v=%0b ill=%0b rw=%0b alu=%b want 1 %0b %0b %b",
                           i, t_instr[i], out_valid, illegal, reg_write, out_alu_op, t_ill[i], t_rw[i], t_alu[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = (i % 2 == 0) ? ADDI : SW;
      in_instr = w; in_pc = 32'h400 + 32'(i * 4);
      tick();
      checks++; if (out_valid !== 1'b1 || out_instr !== w || out_pc !== 32'h400 + 32'(i * 4) || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d]: got v=%0b %h/%h rdy=%0b want 1 %h", i, out_valid, out_instr, out_pc, in_ready, w); end
      if (i % 2 == 1) begin
        checks++; if (mem_write !== 1'b1 || dmem_op !== 3'b001 || reg_write !== 1'b0) begin
          errors++; $display("FAIL b2b_sw[%0d]: got mw=%0b op=%b rw=%0b want 1 001 0", i, mem_write, dmem_op, reg_write); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_hold();
    test_mul();
    test_flush();
    test_mid_reset();
    test_saturate();
    test_table();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
